// File: rtl/pbs_pkg.sv
// Shared types and helpers for the pipelined barrel shifter.
package pbs_pkg;

    // Widest operand the bit_reverse helper can handle.
    localparam int PBS_MAX_N = 256;

    // Legal shift/rotate modes; codes 3'b101..3'b111 are illegal.
    typedef enum logic [2:0] {
        SLL = 3'b000,
        SRL = 3'b001,
        SRA = 3'b010,
        ROL = 3'b011,
        ROR = 3'b100
    } shift_op_t;

    // Width-independent part of a stage payload. The top wraps this with
    // its N-bit data and O-bit remaining amount.
    typedef struct packed {
        shift_op_t op;
        logic      err;
        logic      valid;
    } pbs_ctrl_t;

    // True for the five defined mode codes.
    function automatic logic is_legal(input logic [2:0] op);
        return op <= 3'b100;
    endfunction

    // Right-going modes run through the left datapath on a reversed word.
    function automatic logic is_right(input shift_op_t op);
        return (op == SRL) || (op == SRA) || (op == ROR);
    endfunction

    // Reverse the low n bits of v; bits at and above n come back as 0.
    function automatic logic [PBS_MAX_N-1:0] bit_reverse(
        input logic [PBS_MAX_N-1:0] v,
        input int                   n
    );
        logic [PBS_MAX_N-1:0] r;
        r = '0;
        for (int i = 0; i < PBS_MAX_N; i++) begin
            if (i < n) r[i] = v[n-1-i];
        end
        return r;
    endfunction

    // Number of register stages when l mux levels share one stage.
    function automatic int stage_count(input int o, input int l);
        return (o + l - 1) / l;
    endfunction

endpackage

// File: rtl/pipelined_barrel_shifter_shift_level.sv
// One combinational level of the log shifter: optional left shift by 2^K.
module shift_level
    import pbs_pkg::*;
#(
    parameter int N = 32,
    parameter int K = 0
) (
    input  logic [N-1:0]      data_i,
    input  logic [(1<<K)-1:0] fill_i,
    input  logic              sel_i,
    output logic [N-1:0]      data_o
);

    localparam int W = 1 << K;

    // Pass the word through, or shift it left by W and insert the fill below.
    always_comb begin
        // NOTE: assign a default before any condition so no path leaves
        // data_o unassigned; otherwise a latch is inferred.
        data_o = data_i;
        if (sel_i) data_o = {data_i[N-W-1:0], fill_i};
    end

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter: five shift/rotate modes, a register stage
// every L mux levels, and a single global stall enable.
module pipelined_barrel_shifter
    import pbs_pkg::*;
#(
    parameter int N = 32,
    parameter int O = $clog2(N),
    parameter int L = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_a,
    input  logic [O-1:0] in_b,
    input  logic [2:0]   in_op,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_c,
    output logic         out_zero,
    output logic         out_err
);

    localparam int D = stage_count(O, L);

    typedef struct packed {
        logic [N-1:0] data;
        logic [O-1:0] amount;
        pbs_ctrl_t    ctrl;
    } stage_t;

    // Index of the last mux level that belongs to stage s.
    function automatic int last_level(input int s);
        return (((s + 1) * L < O) ? (s + 1) * L : O) - 1;
    endfunction

    stage_t       stage_in [D];   // payload entering each stage's levels
    stage_t       stage_d  [D];   // payload leaving each stage's levels
    stage_t       stage_q  [D];   // stage registers; the last one drives the outputs
    logic [N-1:0] lvl_out  [O];   // output of every mux level
    logic [N-1:0] final_data;
    logic         zero_d;
    logic         zero_q;
    logic         en;

    // Whole pipe moves when the output slot is empty or being drained.
    assign en       = out_ready | ~stage_q[D-1].ctrl.valid;
    assign in_ready = en;

    // Decode the new transaction into the stage-0 payload and chain later stages.
    always_comb begin
        logic      legal;
        shift_op_t op0;
        legal = is_legal(in_op);
        op0   = legal ? shift_op_t'(in_op) : SLL;
        // Illegal codes shift by zero so the operand passes through untouched.
        stage_in[0].ctrl.valid = in_valid & en;
        stage_in[0].ctrl.err   = ~legal;
        stage_in[0].ctrl.op    = op0;
        stage_in[0].amount     = legal ? in_b : '0;
        stage_in[0].data       = is_right(op0) ? N'(bit_reverse(PBS_MAX_N'(in_a), N)) : in_a;
        for (int s = 1; s < D; s++) begin
            stage_in[s] = stage_q[s-1];
        end
    end

    for (genvar k = 0; k < O; k++) begin : g_level
        localparam int S  = k / L;
        localparam int FW = 1 << k;

        logic [N-1:0]  lvl_in;
        logic [N-1:0]  lvl_o;
        logic [FW-1:0] fill;

        // First level of a stage reads the stage input; others chain.
        if (k % L == 0) begin : g_first
            assign lvl_in = stage_in[S].data;
        end else begin : g_chain
            assign lvl_in = g_level[k-1].lvl_o;
        end

        // Bits shifted into the vacated positions at this level.
        always_comb begin
            fill = '0;
            case (stage_in[S].ctrl.op)
                // Reversed word keeps the original sign bit at bit 0 throughout.
                SRA:      fill = {FW{lvl_in[0]}};
                // Rotates re-insert the bits that fall off the top.
                ROL, ROR: fill = lvl_in[N-1 -: FW];
                default:  fill = '0;
            endcase
        end

        shift_level #(
            .N (N),
            .K (k)
        ) u_shift_level (
            .data_i (lvl_in),
            .fill_i (fill),
            .sel_i  (stage_in[S].amount[k]),
            .data_o (lvl_o)
        );

        assign lvl_out[k] = lvl_o;
    end

    // Next value of each stage register; the last stage un-reverses and flags zero.
    always_comb begin
        for (int s = 0; s < D; s++) begin
            stage_d[s]      = stage_in[s];
            stage_d[s].data = lvl_out[last_level(s)];
        end
        final_data = is_right(stage_in[D-1].ctrl.op)
                   ? N'(bit_reverse(PBS_MAX_N'(lvl_out[O-1]), N))
                   : lvl_out[O-1];
        stage_d[D-1].data = final_data;
        zero_d            = (final_data == '0);
    end

    // Advance every stage together on the global enable; otherwise hold, bubbles included.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: intermediate payloads are don't-care behind a cleared valid,
            // so only the valids and the visible output stage are reset.
            for (int s = 0; s < D; s++) begin
                stage_q[s].ctrl.valid <= 1'b0;
            end
            stage_q[D-1] <= '0;
            zero_q       <= 1'b0;
        end else if (en) begin
            // NOTE: non-blocking so every stage samples its upstream's old value.
            stage_q <= stage_d;
            zero_q  <= zero_d;
        end
    end

    assign out_valid = stage_q[D-1].ctrl.valid;
    assign out_c     = stage_q[D-1].data;
    assign out_err   = stage_q[D-1].ctrl.err;
    assign out_zero  = zero_q;

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Self-checking bench for pipelined_barrel_shifter: directed scenarios on
// N=8/L=1 plus random streams on N=8/L=3 and N=32/L=2 against a reference model.
module tb_pipelined_barrel_shifter;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // DUT A: N=8, L=1, D=3
    logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_zero, a_out_err;
    logic [7:0] a_in_a, a_out_c;
    logic [2:0] a_in_b, a_in_op;
    // DUT B: N=8, L=3, D=1
    logic       b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_zero, b_out_err;
    logic [7:0] b_in_a, b_out_c;
    logic [2:0] b_in_b, b_in_op;
    // DUT C: N=32, L=2, D=3
    logic        c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_out_zero, c_out_err;
    logic [31:0] c_in_a, c_out_c;
    logic [4:0]  c_in_b;
    logic [2:0]  c_in_op;

    pipelined_barrel_shifter #(.N(8), .L(1)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_a(a_in_a), .in_b(a_in_b), .in_op(a_in_op), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .out_c(a_out_c), .out_zero(a_out_zero), .out_err(a_out_err));

    pipelined_barrel_shifter #(.N(8), .L(3)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_a(b_in_a), .in_b(b_in_b), .in_op(b_in_op), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .out_c(b_out_c), .out_zero(b_out_zero), .out_err(b_out_err));

    pipelined_barrel_shifter #(.N(32), .L(2)) u_dut_c (
        .clk(clk), .rst_n(rst_n), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .in_a(c_in_a), .in_b(c_in_b), .in_op(c_in_op), .out_valid(c_out_valid),
        .out_ready(c_out_ready), .out_c(c_out_c), .out_zero(c_out_zero), .out_err(c_out_err));

    typedef struct {
        logic [31:0] c;
        logic        zero;
        logic        err;
        int          stamp;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          cur_dut = 0;
    int          cur_d = 3;
    bit          lat_chk = 0;
    bit          stall_prev = 0;
    logic [31:0] held_c;
    logic        held_z, held_e;

    function automatic exp_t mk(input logic [31:0] c, input logic z, input logic e);
        exp_t r;
        r.c = c; r.zero = z; r.err = e; r.stamp = 0;
        return r;
    endfunction

    // Reference model: plain arithmetic on a 64-bit word masked to n bits.
    function automatic exp_t model(input logic [31:0] a, input int b, input logic [2:0] op, input int n);
        logic [63:0] mask, x, r;
        mask = (64'd1 << n) - 64'd1;
        x    = {32'd0, a} & mask;
        case (op)
            3'd0:    r = (x << b) & mask;
            3'd1:    r = x >> b;
            3'd2:    r = x[n-1] ? ((x >> b) | (mask & ~(mask >> b))) : (x >> b);
            3'd3:    r = ((x << b) | (x >> (n - b))) & mask;
            3'd4:    r = ((x >> b) | (x << (n - b))) & mask;
            default: r = x;
        endcase
        return mk(r[31:0], r == 64'd0, op > 3'd4);
    endfunction

    // One clock cycle on the selected DUT: drive, sample at negedge, score, advance.
    task automatic cycle(input bit v, input logic [31:0] a, input logic [4:0] b, input logic [2:0] op,
                         input bit ordy, input exp_t e, output bit acc);
        logic        rdy, ov, oz, oe;
        logic [31:0] oc;
        exp_t        got;
        case (cur_dut)
            0: begin a_in_valid = v; a_in_a = a[7:0]; a_in_b = b[2:0]; a_in_op = op; a_out_ready = ordy; end
            1: begin b_in_valid = v; b_in_a = a[7:0]; b_in_b = b[2:0]; b_in_op = op; b_out_ready = ordy; end
            default: begin c_in_valid = v; c_in_a = a; c_in_b = b; c_in_op = op; c_out_ready = ordy; end
        endcase
        @(negedge clk);
        case (cur_dut)
            0: begin rdy = a_in_ready; ov = a_out_valid; oc = {24'd0, a_out_c}; oz = a_out_zero; oe = a_out_err; end
            1: begin rdy = b_in_ready; ov = b_out_valid; oc = {24'd0, b_out_c}; oz = b_out_zero; oe = b_out_err; end
            default: begin rdy = c_in_ready; ov = c_out_valid; oc = c_out_c; oz = c_out_zero; oe = c_out_err; end
        endcase
        checks++;
        if (ov !== 1'b0 && ov !== 1'b1) begin
            errors++; $display("FAIL out_valid_known: got %b expected 0 or 1", ov);
        end
        checks++;
        if (rdy !== (ordy | ~ov)) begin
            errors++; $display("FAIL in_ready: got %b expected %b (out_valid=%b out_ready=%b)", rdy, ordy | ~ov, ov, ordy);
        end
        if (stall_prev && ov === 1'b1) begin
            checks++;
            if ({oc, oz, oe} !== {held_c, held_z, held_e}) begin
                errors++; $display("FAIL hold_stable: got c=%h z=%b e=%b expected c=%h z=%b e=%b", oc, oz, oe, held_c, held_z, held_e);
            end
        end
        if (ov === 1'b1 && ordy) begin
            checks++;
            if (sb.size() == 0) begin
                errors++; $display("FAIL unexpected_output: got c=%h expected no output", oc);
            end else begin
                got = sb.pop_front();
                checks++;
                if (oc !== got.c) begin
                    errors++; $display("FAIL out_c: got %h expected %h", oc, got.c);
                end
                checks++;
                if (oz !== got.zero) begin
                    errors++; $display("FAIL out_zero: got %b expected %b (c=%h)", oz, got.zero, got.c);
                end
                checks++;
                if (oe !== got.err) begin
                    errors++; $display("FAIL out_err: got %b expected %b (c=%h)", oe, got.err, got.c);
                end
                if (lat_chk) begin
                    checks++;
                    if (cyc - got.stamp != cur_d) begin
                        errors++; $display("FAIL latency: got %0d expected %0d", cyc - got.stamp, cur_d);
                    end
                end
            end
        end
        stall_prev = (ov === 1'b1) && !ordy;
        held_c = oc; held_z = oz; held_e = oe;
        acc = v && (rdy === 1'b1);
        if (acc) begin
            e.stamp = cyc;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Idle until every scored transaction has come out, then watch a few extra cycles.
    task automatic drain();
        bit acc;
        int n;
        n = 0;
        while (sb.size() > 0 && n < 50) begin
            cycle(1'b0, 32'd0, 5'd0, 3'd0, 1'b1, mk(0, 0, 0), acc);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++; $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
        end
        sb.delete();
        for (int i = 0; i < 4; i++) cycle(1'b0, 32'd0, 5'd0, 3'd0, 1'b1, mk(0, 0, 0), acc);
    endtask

    task automatic select_dut(input int dut, input int d);
        cur_dut = dut; cur_d = d; stall_prev = 0; sb.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        a_in_valid = 0; a_in_a = 0; a_in_b = 0; a_in_op = 0; a_out_ready = 1;
        b_in_valid = 0; b_in_a = 0; b_in_b = 0; b_in_op = 0; b_out_ready = 1;
        c_in_valid = 0; c_in_a = 0; c_in_b = 0; c_in_op = 0; c_out_ready = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({a_out_valid, a_out_c, a_out_zero, a_out_err, a_in_ready} !== {1'b0, 8'h00, 1'b0, 1'b0, 1'b1}) begin
            errors++; $display("FAIL reset_a: got v=%b c=%h z=%b e=%b r=%b expected 0 00 0 0 1", a_out_valid, a_out_c, a_out_zero, a_out_err, a_in_ready);
        end
        checks++;
        if ({b_out_valid, b_out_c, b_out_zero, b_out_err, b_in_ready} !== {1'b0, 8'h00, 1'b0, 1'b0, 1'b1}) begin
            errors++; $display("FAIL reset_b: got v=%b c=%h z=%b e=%b r=%b expected 0 00 0 0 1", b_out_valid, b_out_c, b_out_zero, b_out_err, b_in_ready);
        end
        checks++;
        if ({c_out_valid, c_out_c, c_out_zero, c_out_err, c_in_ready} !== {1'b0, 32'h0, 1'b0, 1'b0, 1'b1}) begin
            errors++; $display("FAIL reset_c: got v=%b c=%h z=%b e=%b r=%b expected 0 0 0 0 1", c_out_valid, c_out_c, c_out_zero, c_out_err, c_in_ready);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_modes();
        logic [2:0] ops [5];
        logic [7:0] res [5];
        bit         acc;
        ops = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
        res = '{8'hA8, 8'h16, 8'hF6, 8'hAD, 8'hB6};
        select_dut(0, 3);
        lat_chk = 1;
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 32'hB5, 5'd3, ops[i], 1'b1, mk({24'd0, res[i]}, 1'b0, 1'b0), acc);
            checks++;
            if (!acc) begin errors++; $display("FAIL modes_accept: got 0 expected 1 (op %0d)", i); end
        end
        drain();
    endtask

    task automatic test_zero_amount();
        bit acc;
        select_dut(0, 3);
        lat_chk = 1;
        cycle(1'b1, 32'h00, 5'd5, 3'd0, 1'b1, mk(32'h00, 1'b1, 1'b0), acc);
        cycle(1'b1, 32'h81, 5'd0, 3'd4, 1'b1, mk(32'h81, 1'b0, 1'b0), acc);
        drain();
    endtask

    task automatic test_illegal();
        bit acc;
        select_dut(0, 3);
        lat_chk = 1;
        cycle(1'b1, 32'h3C, 5'd2, 3'b110, 1'b1, mk(32'h3C, 1'b0, 1'b1), acc);
        cycle(1'b1, 32'h3C, 5'd1, 3'b000, 1'b1, mk(32'h78, 1'b0, 1'b0), acc);
        drain();
    endtask

    task automatic test_back_to_back();
        logic [31:0] ta [6];
        logic [4:0]  tb [6];
        logic [2:0]  to [6];
        int          issued, hold_left, n, idx;
        bit          hold_started, ordy, acc, held_any;
        select_dut(0, 3);
        lat_chk = 0;
        for (int i = 0; i < 6; i++) begin
            ta[i] = 32'($urandom_range(0, 255));
            tb[i] = 5'($urandom_range(0, 7));
            to[i] = 3'($urandom_range(0, 4));
        end
        issued = 0; hold_left = 0; n = 0; hold_started = 0; held_any = 0;
        while ((issued < 6 || sb.size() > 0) && n < 100) begin
            if (!hold_started && a_out_valid === 1'b1) begin
                hold_started = 1; hold_left = 4;
            end
            ordy = (hold_left == 0);
            if (hold_left > 0) begin hold_left--; held_any = 1; end
            idx = (issued < 6) ? issued : 0;
            cycle(issued < 6, ta[idx], tb[idx], to[idx], ordy, model(ta[idx], int'(tb[idx]), to[idx], 8), acc);
            if (acc) issued++;
            n++;
        end
        checks++;
        if (issued != 6 || sb.size() != 0) begin
            errors++; $display("FAIL backpressure_done: got issued=%0d pending=%0d expected 6 and 0", issued, sb.size());
        end
        checks++;
        if (!held_any) begin
            errors++; $display("FAIL backpressure_hold: got no hold expected out_valid to trigger a hold");
        end
        drain();
    endtask

    task automatic test_reset_midflight();
        bit acc;
        select_dut(0, 3);
        lat_chk = 1;
        cycle(1'b1, 32'h11, 5'd1, 3'd0, 1'b1, mk(32'h22, 1'b0, 1'b0), acc);
        cycle(1'b1, 32'h12, 5'd1, 3'd0, 1'b1, mk(32'h24, 1'b0, 1'b0), acc);
        rst_n = 1'b0;
        sb.delete();
        cycle(1'b0, 32'd0, 5'd0, 3'd0, 1'b1, mk(0, 0, 0), acc);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (a_out_valid !== 1'b0) begin
                errors++; $display("FAIL reset_flush: got out_valid=%b expected 0 (cycle %0d after reset)", a_out_valid, i);
            end
            cycle(1'b0, 32'd0, 5'd0, 3'd0, 1'b1, mk(0, 0, 0), acc);
        end
        cycle(1'b1, 32'h96, 5'd2, 3'd3, 1'b1, model(32'h96, 2, 3'd3, 8), acc);
        drain();
    endtask

    task automatic test_random(input int dut, input int n, input int d);
        int          issued, cycles, target;
        bit          v, ordy, acc;
        logic [31:0] a;
        logic [4:0]  b;
        logic [2:0]  op;
        select_dut(dut, d);
        for (int ph = 0; ph < 2; ph++) begin
            lat_chk = (ph == 0);
            target  = (ph == 0) ? 600 : 400;
            issued  = 0;
            cycles  = 0;
            while (issued < target && cycles < target * 10) begin
                v    = ($urandom_range(0, 3) != 0);
                a    = $urandom;
                b    = 5'($urandom_range(0, n - 1));
                op   = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
                ordy = (ph == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
                cycle(v, a, b, op, ordy, model(a, int'(b), op, n), acc);
                if (acc) issued++;
                cycles++;
            end
            checks++;
            if (issued < target) begin
                errors++; $display("FAIL random_progress: got %0d accepted expected %0d (dut %0d)", issued, target, dut);
            end
            drain();
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_modes();
        test_zero_amount();
        test_illegal();
        test_back_to_back();
        test_reset_midflight();
        test_random(1, 8, 1);
        test_random(2, 32, 3);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipelined_barrel_shifter.md
Name: pipelined_barrel_shifter

Overview:
- Parametrised, pipelined successor to the structural log-shifter: N-bit operand, log2(N) mux levels, five shift/rotate modes selected per transaction.
- Pipeline registers are inserted every L mux levels, and each transaction carries a valid/ready handshake.
- Sits between the operand-fetch and writeback stages of the BasicCombinationalLogic datapath as the shift unit.

Parameters:
- N, 32: operand/result width in bits; power of two, >= 4.
- O, $clog2(N): shift-amount width (derived; do not override).
- L, 1: mux levels per pipeline stage, 1..O. Pipeline depth D = ceil(O/L).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  input transaction valid.
- in_ready  out  1  unit can accept the input this cycle.
- in_a  in  N  operand.
- in_b  in  O  shift amount, 0..N-1.
- in_op  in  3  mode select.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_c  out  N  result.
- out_zero  out  1  out_c == 0.
- out_err  out  1  illegal in_op was captured.

Behaviour:
- Modes:
  - 000 SLL.
  - 001 SRL.
  - 010 SRA (sign fill from in_a[N-1]).
  - 011 ROL.
  - 100 ROR.
  - 101..111 illegal: result = in_a unchanged, err = 1.
- Right modes are implemented by bit-reversing the operand, running a left-shift datapath, then reversing the result. Fill bit per level is 0 for SLL/SRL, the sign bit for SRA, and the wrapped-out bits for rotates.
- Level k (k = 0..O-1) shifts by 2^k when b[k] = 1. Stage s holds levels s*L .. min((s+1)*L, O)-1. Each stage register carries data, the remaining b bits, op, err and valid.
- Latency: D cycles from the accepting edge (in_valid & in_ready) to out_valid = 1. With L = O, latency is 1.
- Throughput: one transaction per cycle when out_ready stays high.
- Flow control is a single global enable: en = out_ready | ~out_valid, and in_ready = en. When en = 0, every stage holds, including bubbles; bubbles are not collapsed.
- A stage captures on en. Its valid takes the upstream valid, or in_valid & in_ready for stage 0.
- Outputs are registered from the last stage. out_c, out_zero and out_err stay stable while out_valid & ~out_ready.
- out_zero and out_err are computed in the last stage and are valid only when out_valid = 1.
- Amount 0 returns in_a for all legal modes.
- in_b is always < N. Rotates by any amount wrap exactly; no modulo logic is needed.
- Reset values when rst_n = 0 at an edge: all valids 0, out_valid 0, out_c 0, out_zero 0, out_err 0. in_ready is 1 in the cycle after reset, since out_valid = 0.
- Reset mid-operation: all in-flight transactions are discarded. No output appears for transactions accepted before reset.
- Simultaneous accept and emit on the same edge is legal at full rate.

Decomposition:
- Package pbs_pkg:
  - enum shift_op_t {SLL, SRL, SRA, ROL, ROR}.
  - Function bit_reverse(N).
  - Function stage_count(O, L).
  - Stage payload struct typedef (data, amount, op, err, valid).
- One sub-module, shift_level: combinational single level, parameters N and K. Inputs are data, fill vector and sel; output is data shifted left by 2^K with the fill in the vacated bits.
- The top generates O shift_level instances and D register stages.

Test Plan (N=8, O=3, L=1, D=3 unless noted):
1. in_a=0xB5, in_b=3, with each op SLL/SRL/SRA/ROL/ROR in consecutive cycles, out_ready=1 -> out_c = 0xA8, 0x16, 0xF6, 0xAD, 0xB6 on 5 consecutive cycles, first one 3 cycles after the first accept; out_err=0 throughout.
2. in_a=0x00, SLL, in_b=5 -> out_c=0x00, out_zero=1. Then in_a=0x81, ROR, in_b=0 -> out_c=0x81, out_zero=0.
3. in_op=3'b110, in_a=0x3C -> out_c=0x3C, out_err=1. A following legal op has out_err=0.
4. Backpressure: stream 6 transactions, hold out_ready=0 for 4 cycles after the first out_valid -> in_ready=0 during the hold, out_c stable, no loss or duplication, results in order after release.
5. Reset mid-flight: accept 2 transactions, assert rst_n=0 for 1 cycle -> out_valid stays 0 for ≥ D cycles. A new transaction then completes with latency 3.
6. L=3 (D=1) and N=32, L=2 (D=3): random 1000 transactions against a behavioural model -> bit-exact results, measured latency = D.
